// File: rtl/zx_pkg.sv
// Shared constants for the ZX Spectrum I/O port block: port decodes,
// fixed RAM bank numbers and 0x7FFD / 0xFE bit positions.
package zx_pkg;

    // Port decode bits
    localparam int unsigned ULA_PORT_A0   = 0;       // ULA selected when A0 == 0
    localparam logic [7:0]  KEMPSTON_PORT = 8'h1F;
    localparam int unsigned PAGE_A_HI     = 15;      // 0x7FFD selected when A15 == 0
    localparam int unsigned PAGE_A_LO     = 1;       // ... and A1 == 0

    // Fixed RAM banks
    localparam logic [4:0]  BANK_SCREEN   = 5'd5;
    localparam logic [4:0]  BANK_8000     = 5'd2;
    localparam logic [4:0]  BANK_SHADOW   = 5'd7;

    // 0x7FFD bit positions
    localparam int unsigned P7_BANK_MSB   = 2;       // bank bits [2:0]
    localparam int unsigned P7_SCREEN     = 3;
    localparam int unsigned P7_ROM        = 4;
    localparam int unsigned P7_LOCK       = 5;
    localparam int unsigned P7_BANK_B3    = 6;
    localparam int unsigned P7_BANK_B4    = 7;

    // 0xFE bit positions
    localparam int unsigned FE_MIC        = 3;
    localparam int unsigned FE_SOUND      = 4;

    // Full 5-bit bank number carried by a 0x7FFD write
    function automatic logic [4:0] page_bank(input logic [7:0] d);
        return {d[P7_BANK_B4], d[P7_BANK_B3], d[P7_BANK_MSB:0]};
    endfunction

endpackage

// File: rtl/zx_page_reg.sv
// 0x7FFD paging register with sticky lock.
// Ports: clk, rst_n (async active-low), i_wr_en (one-cycle update enable),
//        i_data (CPU data byte), o_ram_bank, o_rom_sel, o_screen_sel, o_locked.
module zx_page_reg
    import zx_pkg::*;
#(
    parameter int unsigned BANK_BITS     = 3,
    parameter int unsigned ENABLE_PAGING = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_data,
    output logic [BANK_BITS-1:0] o_ram_bank,
    output logic                 o_rom_sel,
    output logic                 o_screen_sel,
    output logic                 o_locked
);

    localparam bit PAGING_ON = (ENABLE_PAGING != 0);

    logic [BANK_BITS-1:0] r_ram_bank;
    logic                 r_rom_sel;
    logic                 r_screen_sel;
    logic                 r_locked;

    // Writes are dropped once locked; only reset clears the lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_bank   <= '0;
            r_rom_sel    <= 1'b0;
            r_screen_sel <= 1'b0;
            r_locked     <= 1'b0;
        end else if (i_wr_en && !r_locked && PAGING_ON) begin
            r_ram_bank   <= BANK_BITS'(page_bank(i_data));
            r_screen_sel <= i_data[P7_SCREEN];
            r_rom_sel    <= i_data[P7_ROM];
            r_locked     <= i_data[P7_LOCK];
        end
    end

    // 48K build: fixed mapping, port reads as locked
    assign o_ram_bank   = PAGING_ON ? r_ram_bank   : '0;
    assign o_rom_sel    = PAGING_ON ? r_rom_sel    : 1'b0;
    assign o_screen_sel = PAGING_ON ? r_screen_sel : 1'b0;
    assign o_locked     = PAGING_ON ? r_locked     : 1'b1;

endmodule

// File: rtl/zx_io_ports.sv
// Z80 I/O port state: ULA 0xFE latch, 0x7FFD paging, registered keyboard /
// Kempston read mux and combinational physical bank mapping.
// Ports: clk, reset_n, cpu_addr/cpu_dout, n_iorq/n_wr/n_rd/n_m1 (active low),
//        key_data, ear_in, joy -> border_color, sound, mic, ram_bank, rom_sel,
//        screen_sel, paging_locked, io_rd_data, io_rd_hit (registered),
//        rom_cs, phys_bank (combinational).
module zx_io_ports
    import zx_pkg::*;
#(
    parameter int unsigned NUM_RAM_BANKS = 8,
    parameter int unsigned ENABLE_PAGING = 1,
    parameter int unsigned BORDER_BITS   = 3,
    parameter int unsigned JOY_BITS      = 5,
    localparam int unsigned BANK_BITS    = $clog2(NUM_RAM_BANKS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [15:0]            cpu_addr,
    input  logic [7:0]             cpu_dout,
    input  logic                   n_iorq,
    input  logic                   n_wr,
    input  logic                   n_rd,
    input  logic                   n_m1,
    input  logic [4:0]             key_data,
    input  logic                   ear_in,
    input  logic [JOY_BITS-1:0]    joy,
    output logic [BORDER_BITS-1:0] border_color,
    output logic                   sound,
    output logic                   mic,
    output logic [BANK_BITS-1:0]   ram_bank,
    output logic                   rom_sel,
    output logic                   screen_sel,
    output logic                   paging_locked,
    output logic [7:0]             io_rd_data,
    output logic                   io_rd_hit,
    output logic                   rom_cs,
    output logic [BANK_BITS-1:0]   phys_bank
);

    logic       w_wr_s;
    logic       w_rd_s;
    logic       w_upd;
    logic       w_ula_hit;
    logic       w_page_hit;
    logic       w_kemp_hit;
    logic [7:0] w_rd_data;
    logic       w_rd_hit;
    logic       w_unused_addr;

    logic                   r_wr_q;
    logic [BORDER_BITS-1:0] r_border;
    logic                   r_sound;
    logic                   r_mic;
    logic [7:0]             r_rd_data;
    logic                   r_rd_hit;

    // Interrupt acknowledge (M1 with IORQ) is neither a read nor a write
    assign w_wr_s     = ~n_iorq & ~n_wr & n_m1;
    assign w_rd_s     = ~n_iorq & ~n_rd & n_m1;
    assign w_upd      = w_wr_s & ~r_wr_q;
    assign w_ula_hit  = ~cpu_addr[ULA_PORT_A0];
    assign w_page_hit = ~cpu_addr[PAGE_A_HI] & ~cpu_addr[PAGE_A_LO];
    assign w_kemp_hit = (cpu_addr[7:0] == KEMPSTON_PORT);
    assign w_unused_addr = ^cpu_addr[13:8];

    // Write edge detect and 0xFE latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q   <= 1'b0;
            r_border <= '0;
            r_sound  <= 1'b0;
            r_mic    <= 1'b0;
        end else begin
            r_wr_q <= w_wr_s;
            if (w_upd && w_ula_hit) begin
                r_border <= cpu_dout[BORDER_BITS-1:0];
                r_mic    <= cpu_dout[FE_MIC];
                r_sound  <= cpu_dout[FE_SOUND];
            end
        end
    end

    zx_page_reg #(
        .BANK_BITS     (BANK_BITS),
        .ENABLE_PAGING (ENABLE_PAGING)
    ) u_page_reg (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_wr_en      (w_upd & w_page_hit),
        .i_data       (cpu_dout),
        .o_ram_bank   (ram_bank),
        .o_rom_sel    (rom_sel),
        .o_screen_sel (screen_sel),
        .o_locked     (paging_locked)
    );

    // Read mux, Kempston before ULA
    always_comb begin
        w_rd_data = 8'hFF;
        w_rd_hit  = 1'b0;
        if (w_rd_s) begin
            if (w_kemp_hit) begin
                w_rd_data = 8'(joy);
                w_rd_hit  = 1'b1;
            end else if (w_ula_hit) begin
                w_rd_data = {1'b1, ear_in, 1'b1, key_data};
                w_rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= 8'hFF;
            r_rd_hit  <= 1'b0;
        end else begin
            r_rd_data <= w_rd_data;
            r_rd_hit  <= w_rd_hit;
        end
    end

    // Physical bank for the current CPU address; ROM area drives 0
    always_comb begin
        phys_bank = '0;
        case (cpu_addr[15:14])
            2'b01:   phys_bank = BANK_BITS'(BANK_SCREEN);
            2'b10:   phys_bank = BANK_BITS'(BANK_8000);
            2'b11:   phys_bank = ram_bank;
            default: phys_bank = '0;
        endcase
    end

    assign rom_cs       = (cpu_addr[15:14] == 2'b00);
    assign border_color = r_border;
    assign sound        = r_sound;
    assign mic          = r_mic;
    assign io_rd_data   = r_rd_data;
    assign io_rd_hit    = r_rd_hit;

endmodule

// File: tb/tb_zx_io_ports.sv
// Directed bench for zx_io_ports: 8-bank, 32-bank and 48K builds share one bus.
module tb_zx_io_ports;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        n_iorq, n_wr, n_rd, n_m1;
    logic [4:0]  key_data;
    logic        ear_in;
    logic [4:0]  joy;

    // 8-bank build
    logic [2:0] a_border, a_ram, a_phys;
    logic       a_sound, a_mic, a_rom, a_scr, a_lock, a_hit, a_romcs;
    logic [7:0] a_rd;
    // 32-bank build
    logic [2:0] b_border;
    logic [4:0] b_ram, b_phys;
    logic       b_sound, b_mic, b_rom, b_scr, b_lock, b_hit, b_romcs;
    logic [7:0] b_rd;
    // 48K build
    logic [2:0] c_border, c_ram, c_phys;
    logic       c_sound, c_mic, c_rom, c_scr, c_lock, c_hit, c_romcs;
    logic [7:0] c_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zx_io_ports #(.NUM_RAM_BANKS(8), .ENABLE_PAGING(1)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .joy(joy),
        .border_color(a_border), .sound(a_sound), .mic(a_mic), .ram_bank(a_ram),
        .rom_sel(a_rom), .screen_sel(a_scr), .paging_locked(a_lock),
        .io_rd_data(a_rd), .io_rd_hit(a_hit), .rom_cs(a_romcs), .phys_bank(a_phys)
    );

    zx_io_ports #(.NUM_RAM_BANKS(32), .ENABLE_PAGING(1)) dut32 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .joy(joy),
        .border_color(b_border), .sound(b_sound), .mic(b_mic), .ram_bank(b_ram),
        .rom_sel(b_rom), .screen_sel(b_scr), .paging_locked(b_lock),
        .io_rd_data(b_rd), .io_rd_hit(b_hit), .rom_cs(b_romcs), .phys_bank(b_phys)
    );

    zx_io_ports #(.NUM_RAM_BANKS(8), .ENABLE_PAGING(0)) dut48 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .joy(joy),
        .border_color(c_border), .sound(c_sound), .mic(c_mic), .ram_bank(c_ram),
        .rom_sel(c_rom), .screen_sel(c_scr), .paging_locked(c_lock),
        .io_rd_data(c_rd), .io_rd_hit(c_hit), .rom_cs(c_romcs), .phys_bank(c_phys)
    );

    typedef struct {
        logic [15:0] addr;
        logic [4:0]  key;
        logic        ear;
        logic [4:0]  joy;
        logic        m1_n;
        logic [7:0]  exp_data;
        logic        exp_hit;
    } rd_vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        exp_romcs;
        logic [2:0]  exp_phys;
    } map_vec_t;

    rd_vec_t  rd_tab [6];
    map_vec_t map_tab[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One-cycle OUT; returns on the negedge after the update edge
    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; n_iorq = 1'b0; n_wr = 1'b0;
        @(negedge clk);
        n_iorq = 1'b1; n_wr = 1'b1;
    endtask

    initial begin
        rd_tab[0] = '{16'hFEFE, 5'h1E, 1'b0, 5'h00, 1'b1, 8'hBE, 1'b1};
        rd_tab[1] = '{16'h001F, 5'h1F, 1'b1, 5'h11, 1'b1, 8'h11, 1'b1};
        rd_tab[2] = '{16'h00FF, 5'h1F, 1'b1, 5'h11, 1'b1, 8'hFF, 1'b0};
        rd_tab[3] = '{16'h7FFE, 5'h05, 1'b1, 5'h00, 1'b1, 8'hE5, 1'b1};
        rd_tab[4] = '{16'h00FE, 5'h00, 1'b0, 5'h1F, 1'b0, 8'hFF, 1'b0};
        rd_tab[5] = '{16'h011F, 5'h00, 1'b0, 5'h1F, 1'b1, 8'h1F, 1'b1};

        map_tab[0] = '{16'hC123, 1'b0, 3'd3};
        map_tab[1] = '{16'h4000, 1'b0, 3'd5};
        map_tab[2] = '{16'h8000, 1'b0, 3'd2};
        map_tab[3] = '{16'h1234, 1'b1, 3'd0};
        map_tab[4] = '{16'hFFFF, 1'b0, 3'd3};

        reset_n = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
        n_iorq = 1'b1; n_wr = 1'b1; n_rd = 1'b1; n_m1 = 1'b1;
        key_data = 5'h1F; ear_in = 1'b1; joy = 5'h00;
        repeat (2) @(negedge clk);

        chk("rst_border", a_border, 3'd0);
        chk("rst_sound",  a_sound,  1'b0);
        chk("rst_mic",    a_mic,    1'b0);
        chk("rst_ram",    a_ram,    3'd0);
        chk("rst_rom",    a_rom,    1'b0);
        chk("rst_scr",    a_scr,    1'b0);
        chk("rst_lock",   a_lock,   1'b0);
        chk("rst_rd",     a_rd,     8'hFF);
        chk("rst_hit",    a_hit,    1'b0);
        chk("rst_lock48", c_lock,   1'b1);
        reset_n = 1'b1;

        // Strobe held 3 cycles; data changed mid-strobe must not be applied
        @(negedge clk);
        cpu_addr = 16'h00FE; cpu_dout = 8'h15; n_iorq = 1'b0; n_wr = 1'b0;
        @(negedge clk);
        cpu_dout = 8'h02;
        repeat (2) @(negedge clk);
        n_iorq = 1'b1; n_wr = 1'b1;
        chk("held_border", a_border, 3'd5);
        chk("held_sound",  a_sound,  1'b1);
        chk("held_mic",    a_mic,    1'b0);

        // Interrupt acknowledge must not write
        @(negedge clk);
        cpu_dout = 8'h07; n_iorq = 1'b0; n_wr = 1'b0; n_m1 = 1'b0;
        @(negedge clk);
        n_iorq = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
        chk("ack_border", a_border, 3'd5);

        io_write(16'h7FFD, 8'h13);
        chk("p13_ram",    a_ram,    3'd3);
        chk("p13_rom",    a_rom,    1'b1);
        chk("p13_scr",    a_scr,    1'b0);
        chk("p13_lock",   a_lock,   1'b0);
        chk("p13_border", a_border, 3'd5);

        foreach (map_tab[i]) begin
            cpu_addr = map_tab[i].addr;
            #1;
            chk($sformatf("map%0d_romcs", i), a_romcs, map_tab[i].exp_romcs);
            chk($sformatf("map%0d_phys", i),  a_phys,  map_tab[i].exp_phys);
        end

        foreach (rd_tab[i]) begin
            @(negedge clk);
            cpu_addr = rd_tab[i].addr; key_data = rd_tab[i].key;
            ear_in = rd_tab[i].ear; joy = rd_tab[i].joy; n_m1 = rd_tab[i].m1_n;
            n_iorq = 1'b0; n_rd = 1'b0;
            @(negedge clk);
            chk($sformatf("rd%0d_data", i), a_rd,  rd_tab[i].exp_data);
            chk($sformatf("rd%0d_hit", i),  a_hit, rd_tab[i].exp_hit);
        end
        n_iorq = 1'b1; n_rd = 1'b1; n_m1 = 1'b1;
        @(negedge clk);
        chk("rd_idle_data", a_rd,  8'hFF);
        chk("rd_idle_hit",  a_hit, 1'b0);

        // Bank width truncation across builds
        io_write(16'h7FFD, 8'hC5);
        chk("c5_ram8",  a_ram, 3'd5);
        chk("c5_ram32", b_ram, 5'h1D);
        chk("c5_ram48", c_ram, 3'd0);
        cpu_addr = 16'hC000;
        #1;
        chk("c5_phys8",  a_phys, 3'd5);
        chk("c5_phys32", b_phys, 5'h1D);
        chk("c5_phys48", c_phys, 3'd0);

        // Lock, then a second write that must be ignored
        io_write(16'h7FFD, 8'h24);
        chk("p24_ram",  a_ram,  3'd4);
        chk("p24_lock", a_lock, 1'b1);
        io_write(16'h7FFD, 8'h07);
        chk("p07_ram",  a_ram,  3'd4);
        chk("p07_lock", a_lock, 1'b1);
        chk("p07_rom",  a_rom,  1'b0);

        // Async reset mid-strobe, checked between clock edges
        @(negedge clk);
        cpu_addr = 16'h00FE; cpu_dout = 8'h1F; n_iorq = 1'b0; n_wr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_border", a_border, 3'd0);
        chk("arst_sound",  a_sound,  1'b0);
        chk("arst_ram",    a_ram,    3'd0);
        chk("arst_lock",   a_lock,   1'b0);
        @(negedge clk);
        n_iorq = 1'b1; n_wr = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // Both decodes in one write
        io_write(16'h7FFC, 8'h3A);
        chk("dual_border", a_border, 3'd2);
        chk("dual_sound",  a_sound,  1'b1);
        chk("dual_mic",    a_mic,    1'b1);
        chk("dual_ram",    a_ram,    3'd2);
        chk("dual_scr",    a_scr,    1'b1);
        chk("dual_rom",    a_rom,    1'b1);
        chk("dual_lock",   a_lock,   1'b1);
        chk("dual48_ram",    c_ram,    3'd0);
        chk("dual48_lock",   c_lock,   1'b1);
        chk("dual48_border", c_border, 3'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
